// File: rtl/regfile_2r1w_clr.sv
// Register file: one write port, two registered read ports, hardware clear sequencer.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding per read port.
module regfile_2r1w_clr #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DATA_W-1:0]   rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0]   rdata_b_q, rdata_b_d;
  logic                rvalid_q, rvalid_d;
  logic [DEPTH-1:0]    we_dec;
  logic                idle;

  assign idle = (state_q == StIdle);

  // One-hot write-enable decoder; writes only land while the sequencer is idle.
  always_comb begin
    we_dec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      we_dec[i] = we && idle && (waddr == ADDR_W'(i));
    end
    if (ZERO_REG != 0) we_dec[0] = 1'b0;
  end

  // Next-state for storage, clear sequencer and read ports.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_d     = mem_q;
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    rvalid_d  = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      if (we_dec[i]) mem_d[i] = wdata;
    end

    unique case (state_q)
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        mem_d[cnt_q] = '0;
        cnt_d        = cnt_q + 1'b1;  // wraps to 0 exactly on the last entry
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (idle && re) begin
      rvalid_d  = 1'b1;
      rdata_a_d = mem_q[raddr_a];
      rdata_b_d = mem_q[raddr_b];
`ifdef REGFILE_BYPASS_EN
      if (we && raddr_a == waddr) rdata_a_d = wdata;
      if (we && raddr_b == waddr) rdata_b_d = wdata;
`endif
      // Zero register override last so forwarding never leaks into entry 0.
      if (ZERO_REG != 0 && raddr_a == '0) rdata_a_d = '0;
      if (ZERO_REG != 0 && raddr_b == '0) rdata_b_d = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
      rvalid_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
      rvalid_q  <= rvalid_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign rvalid   = rvalid_q;
  assign clr_busy = (state_q == StClear);
  assign clr_done = (state_q == StDone);

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Directed self-checking bench for regfile_2r1w_clr (default parameters).
module tb_regfile_2r1w_clr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re;
  logic [4:0]  raddr_a, raddr_b;
  logic [31:0] rdata_a, rdata_b;
  logic        rvalid;
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;

  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt;
  int bad_cnt;

  regfile_2r1w_clr dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re       (re),
    .raddr_a  (raddr_a),
    .raddr_b  (raddr_b),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b),
    .rvalid   (rvalid),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; re = 1'b0;
    raddr_a = '0; raddr_b = '0; clr_req = 1'b0;

    // Reset state, driven inputs active to show they are ignored.
    re = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h5; clr_req = 1'b1;
    tick(); tick();
    check("rst_rdata_a", rdata_a, 32'h0);
    check("rst_rdata_b", rdata_b, 32'h0);
    check("rst_rvalid", {31'b0, rvalid}, 32'h0);
    check("rst_clr_busy", {31'b0, clr_busy}, 32'h0);
    check("rst_clr_done", {31'b0, clr_done}, 32'h0);
    we = 1'b0; clr_req = 1'b0; re = 1'b0;
    rst_n = 1'b1;

    // Read after reset.
    re = 1'b1; raddr_a = 5'd3; raddr_b = 5'd31;
    tick();
    re = 1'b0;
    check("rd0_a", rdata_a, 32'h0);
    check("rd0_b", rdata_b, 32'h0);
    check("rd0_rvalid", {31'b0, rvalid}, 32'h1);

    // Write/read-back, entry 0 write dropped.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    waddr = 5'd0; wdata = 32'h1234;
    tick();
    we = 1'b0; re = 1'b1; raddr_a = 5'd5; raddr_b = 5'd0;
    tick();
    re = 1'b0;
    check("wr5_a", rdata_a, 32'hDEADBEEF);
    check("zero_b", rdata_b, 32'h0);
    check("wr_rvalid", {31'b0, rvalid}, 32'h1);
    tick();
    check("idle_rvalid", {31'b0, rvalid}, 32'h0);
    check("hold_a", rdata_a, 32'hDEADBEEF);

    // Same-cycle read/write hazard on entry 7.
    we = 1'b1; waddr = 5'd7; wdata = 32'h11;
    tick();
    wdata = 32'h22; re = 1'b1; raddr_a = 5'd7; raddr_b = 5'd5;
    tick();
    we = 1'b0; re = 1'b0;
`ifdef REGFILE_BYPASS_EN
    check("hazard_a", rdata_a, 32'h22);
`else
    check("hazard_a", rdata_a, 32'h11);
`endif
    check("hazard_b", rdata_b, 32'hDEADBEEF);
    re = 1'b1; raddr_a = 5'd7;
    tick();
    re = 1'b0;
    check("hazard_next", rdata_a, 32'h22);

    // Fill all entries with index+1.
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 32'(i + 1);
      tick();
    end
    we = 1'b0;
    re = 1'b1; raddr_a = 5'd20; raddr_b = 5'd31;
    tick();
    re = 1'b0;
    check("fill_20", rdata_a, 32'd21);
    check("fill_31", rdata_b, 32'd32);

    // Clear sweep with writes, reads and clr_req re-pulse issued during the sweep.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    we = 1'b1; waddr = 5'd3; wdata = 32'hFF; re = 1'b1; raddr_a = 5'd4; raddr_b = 5'd6;
    busy_cnt = 0; bad_cnt = 0;
    for (int c = 0; c < 100 && clr_busy; c++) begin
      busy_cnt++;
      if (rvalid !== 1'b0 || clr_done !== 1'b0) bad_cnt++;
      clr_req = (busy_cnt == 5);
      tick();
    end
    clr_req = 1'b0;
    check("clr_busy_len", 32'(busy_cnt), 32'd32);
    check("clr_sweep_quiet", 32'(bad_cnt), 32'd0);
    check("clr_done_pulse", {31'b0, clr_done}, 32'h1);
    check("clr_done_rvalid", {31'b0, rvalid}, 32'h0);
    check("clr_rdata_hold", rdata_a, 32'd21);
    we = 1'b0; re = 1'b0;
    tick();
    check("clr_done_end", {31'b0, clr_done}, 32'h0);
    check("no_extra_seq0", {31'b0, clr_busy}, 32'h0);
    tick();
    check("no_extra_seq1", {31'b0, clr_busy}, 32'h0);

    bad_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      re = 1'b1; raddr_a = 5'(i); raddr_b = 5'(31 - i);
      tick();
      if (rdata_a !== 32'h0 || rdata_b !== 32'h0 || rvalid !== 1'b1) bad_cnt++;
    end
    re = 1'b0;
    check("cleared_entries", 32'(bad_cnt), 32'd0);

    // Simultaneous write and clear request in idle.
    we = 1'b1; waddr = 5'd9; wdata = 32'hAA; clr_req = 1'b1;
    tick();
    we = 1'b0; clr_req = 1'b0;
    check("sim_busy", {31'b0, clr_busy}, 32'h1);
    for (int c = 0; c < 100 && !clr_done; c++) tick();
    check("sim_done", {31'b0, clr_done}, 32'h1);
    tick();
    re = 1'b1; raddr_a = 5'd9; raddr_b = 5'd10;
    tick();
    re = 1'b0;
    check("sim_entry9", rdata_a, 32'h0);
    check("sim_rvalid", {31'b0, rvalid}, 32'h1);

    // Reset in the middle of a sweep.
    we = 1'b1; waddr = 5'd25; wdata = 32'h55;
    tick();
    we = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check("mid_busy", {31'b0, clr_busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, clr_busy}, 32'h0);
    check("mid_rst_done", {31'b0, clr_done}, 32'h0);
    tick();
    rst_n = 1'b1;
    we = 1'b1; waddr = 5'd12; wdata = 32'h77; re = 1'b1; raddr_a = 5'd25; raddr_b = 5'd1;
    tick();
    we = 1'b0;
    check("post_rst_done", {31'b0, clr_done}, 32'h0);
    check("post_rst_25", rdata_a, 32'h0);
    check("post_rst_1", rdata_b, 32'h0);
    raddr_a = 5'd12; raddr_b = 5'd20;
    tick();
    re = 1'b0;
    check("post_rst_wr12", rdata_a, 32'h77);
    check("post_rst_20", rdata_b, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
